// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int                        DEFAULT_DATA_W   = 160;
    localparam int                        DEFAULT_CTRL_W   = 9;
    localparam logic [DEFAULT_CTRL_W-1:0] DEFAULT_NOP_CTRL = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: payload, control bits and a valid flag.
// Clear squashes the valid flag and blocks any load in the same cycle.
module pipe_entry_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 9
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    assign valid_d = valid_i & ~clear_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            // NOTE: payload is reset too, so out_data reads zero straight out of reset.
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            // NOTE: non-blocking so every entry register samples pre-edge values.
            valid_q <= valid_d;
            if (load_i && !clear_i) begin
                data_q <= data_i;
                ctrl_q <= ctrl_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with flush and optional 2-entry skid buffer.
// SKID=1 gives a registered in_ready; SKID=0 gives a single register with comb in_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                CTRL_W   = DEFAULT_CTRL_W,
    parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(DEFAULT_NOP_CTRL),
    parameter int                SKID     = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              accept, consume;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : NOP_CTRL;

    if (SKID != 0) begin : g_skid
        pipe_state_t       state_q, state_d;
        logic              main_load, skid_load;
        logic              skid_valid;
        logic [DATA_W-1:0] skid_data, main_src_data;
        logic [CTRL_W-1:0] skid_ctrl, main_src_ctrl;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) state_q <= EMPTY;
            else          state_q <= state_d;
        end

        always_comb begin
            // NOTE: defaults first so no path through this block can infer a latch.
            state_d   = state_q;
            main_load = 1'b0;
            skid_load = 1'b0;
            case (state_q)
                EMPTY: if (accept) begin
                    state_d   = BUSY;
                    main_load = 1'b1;
                end
                BUSY: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (consume) begin
                    state_d   = BUSY;
                    main_load = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
            if (flush) begin
                state_d   = EMPTY;
                main_load = 1'b0;
                skid_load = 1'b0;
            end
        end

        // Ready depends only on the registered state, never on out_ready.
        assign in_ready      = (state_q != FULL);
        assign main_src_data = skid_valid ? skid_data : in_data;
        assign main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;

        pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
            .clock   (clock),
            .reset_n (reset_n),
            .clear_i (flush),
            .load_i  (main_load),
            .valid_i (state_d != EMPTY),
            .data_i  (main_src_data),
            .ctrl_i  (main_src_ctrl),
            .valid_o (main_valid),
            .data_o  (main_data),
            .ctrl_o  (main_ctrl)
        );

        pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .clock   (clock),
            .reset_n (reset_n),
            .clear_i (flush),
            .load_i  (skid_load),
            .valid_i (state_d == FULL),
            .data_i  (in_data),
            .ctrl_i  (in_ctrl),
            .valid_o (skid_valid),
            .data_o  (skid_data),
            .ctrl_o  (skid_ctrl)
        );
    end else begin : g_single
        logic main_load;

        assign in_ready  = ~main_valid | out_ready;
        assign main_load = accept & ~flush;

        pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
            .clock   (clock),
            .reset_n (reset_n),
            .clear_i (flush),
            .load_i  (main_load),
            .valid_i (main_load | (main_valid & ~consume)),
            .data_i  (in_data),
            .ctrl_i  (in_ctrl),
            .valid_o (main_valid),
            .data_o  (main_data),
            .ctrl_o  (main_ctrl)
        );
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and random checks of pipe_stage_elastic, SKID=1 (s1) and SKID=0 (s0) side by side.
module tb_pipe_stage_elastic;

    localparam int             DW  = 16;
    localparam int             CW  = 9;
    localparam logic [CW-1:0]  NOP = '0;

    logic          clock = 1'b0;
    logic          reset_n, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          s1_in_ready, s1_out_valid, s0_in_ready, s0_out_valid;
    logic [DW-1:0] s1_out_data, s0_out_data;
    logic [CW-1:0] s1_out_ctrl, s0_out_ctrl;

    logic [CW+DW-1:0] q1[$];
    logic [CW+DW-1:0] q0[$];
    int checks = 0, passed = 0, fails = 0;
    int acc0 = 0, con0 = 0;

    always #5 clock = ~clock;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .SKID(1)) u_s1 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s1_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_data(s1_out_data), .out_ctrl(s1_out_ctrl)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .SKID(0)) u_s0 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard step for one DUT, using the values sampled this cycle.
    task automatic sb(input int id, input logic rdy, input logic vld,
                      input logic [DW-1:0] od, input logic [CW-1:0] oc);
        logic [CW+DW-1:0] exp;
        logic acc, con;
        acc = in_valid & rdy;
        con = vld & out_ready;
        if (!vld) check($sformatf("s%0d_nop_ctrl", id), 32'(oc), 32'(NOP));
        if (id == 1) begin
            if (con) begin
                if (q1.size() == 0) check("s1_extra_out", 32'(vld), 32'd0);
                else begin
                    exp = q1.pop_front();
                    check("s1_order", 32'({oc, od}), 32'(exp));
                end
            end
            if (flush) q1.delete();
            else if (acc) q1.push_back({in_ctrl, in_data});
        end else begin
            if (con) begin
                con0++;
                if (q0.size() == 0) check("s0_extra_out", 32'(vld), 32'd0);
                else begin
                    exp = q0.pop_front();
                    check("s0_order", 32'({oc, od}), 32'(exp));
                end
            end
            if (flush) q0.delete();
            else if (acc) begin
                acc0++;
                q0.push_back({in_ctrl, in_data});
            end
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then sample before the rising edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f);
        @(negedge clock);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        #1;
        sb(1, s1_in_ready, s1_out_valid, s1_out_data, s1_out_ctrl);
        sb(0, s0_in_ready, s0_out_valid, s0_out_data, s0_out_ctrl);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_s1_valid", 32'(s1_out_valid), 32'd0);
        check("rst_s1_ctrl",  32'(s1_out_ctrl),  32'(NOP));
        check("rst_s1_data",  32'(s1_out_data),  32'd0);
        check("rst_s1_ready", 32'(s1_in_ready),  32'd1);
        check("rst_s0_valid", 32'(s0_out_valid), 32'd0);
        check("rst_s0_ready", 32'(s0_in_ready),  32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Streaming: 8 back-to-back entries, 1-cycle latency, no gaps.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, DW'(16'hA0 + i), CW'(9'h100 + i), 1'b1, 1'b0);
            if (i > 0) begin
                check("stream_s1_valid", 32'(s1_out_valid), 32'd1);
                check("stream_s1_data",  32'(s1_out_data),  32'(16'hA0 + i - 1));
                check("stream_s0_valid", 32'(s0_out_valid), 32'd1);
                check("stream_s0_data",  32'(s0_out_data),  32'(16'hA0 + i - 1));
            end
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_s1_last", 32'(s1_out_data), 32'h00A7);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_s1_idle", 32'(s1_out_valid), 32'd0);
        check("stream_s0_idle", 32'(s0_out_valid), 32'd0);

        // Stall: skid fills, in_ready drops, head held, then release without loss.
        cycle(1'b1, 16'hA0, 9'h011, 1'b1, 1'b0);
        check("stall_s1_empty", 32'(s1_out_valid), 32'd0);
        cycle(1'b1, 16'hA1, 9'h022, 1'b0, 1'b0);
        check("stall_s1_head",  32'(s1_out_data),  32'h00A0);
        check("stall_s1_rdy1",  32'(s1_in_ready),  32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'hA2, 9'h033, 1'b0, 1'b0);
            check("stall_s1_rdy0", 32'(s1_in_ready), 32'd0);
            check("stall_s1_held", 32'(s1_out_data), 32'h00A0);
        end
        cycle(1'b1, 16'hA2, 9'h033, 1'b1, 1'b0);
        check("stall_s1_out0", 32'(s1_out_data), 32'h00A0);
        check("stall_s1_rdy_full", 32'(s1_in_ready), 32'd0);
        cycle(1'b1, 16'hA2, 9'h033, 1'b1, 1'b0);
        check("stall_s1_out1", 32'(s1_out_data), 32'h00A1);
        check("stall_s1_rdy_back", 32'(s1_in_ready), 32'd1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("stall_s1_out2", 32'(s1_out_data), 32'h00A2);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("stall_s1_drained", 32'(s1_out_valid), 32'd0);
        check("stall_s1_sb_empty", 32'(q1.size()), 32'd0);

        // Flush from FULL with a concurrent in_valid that must be dropped.
        cycle(1'b1, 16'hA0, 9'h044, 1'b1, 1'b0);
        cycle(1'b1, 16'hA1, 9'h055, 1'b0, 1'b0);
        cycle(1'b1, 16'hFF, 9'h1FF, 1'b0, 1'b1);
        check("flush_s1_full", 32'(s1_in_ready), 32'd0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("flush_s1_valid", 32'(s1_out_valid), 32'd0);
        check("flush_s1_ready", 32'(s1_in_ready),  32'd1);
        check("flush_s1_data",  32'(s1_out_data),  32'h00A0);
        check("flush_s0_valid", 32'(s0_out_valid), 32'd0);
        // Flush with a concurrent consume: head still delivered, next entry squashed.
        cycle(1'b1, 16'hB0, 9'h066, 1'b1, 1'b0);
        cycle(1'b1, 16'hB1, 9'h077, 1'b1, 1'b1);
        cycle(1'b1, 16'hB2, 9'h088, 1'b1, 1'b0);
        check("flush_cons_s1_valid", 32'(s1_out_valid), 32'd0);
        check("flush_cons_s0_valid", 32'(s0_out_valid), 32'd0);
        repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // SKID=0: in_ready follows out_ready combinationally while the head is valid.
        acc0 = 0;
        con0 = 0;
        cycle(1'b1, 16'hC0, 9'h099, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, DW'(16'hC1 + i), CW'(9'h0C0 + i), (i % 2) == 1, 1'b0);
            check("comb_s0_ready", 32'(s0_in_ready), 32'((i % 2) == 1));
            check("comb_s0_valid", 32'(s0_out_valid), 32'd1);
        end
        check("comb_s0_counts", 32'(acc0), 32'(con0 + 1));
        repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("comb_s0_drained", 32'(acc0), 32'(con0));

        // Reset asserted mid-stream: outputs drop asynchronously.
        cycle(1'b1, 16'hD0, 9'h0AA, 1'b0, 1'b0);
        cycle(1'b1, 16'hD1, 9'h0BB, 1'b0, 1'b0);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 16'hD2;
        #2 reset_n = 1'b0;
        #1;
        check("arst_s1_valid", 32'(s1_out_valid), 32'd0);
        check("arst_s1_ctrl",  32'(s1_out_ctrl),  32'(NOP));
        check("arst_s0_valid", 32'(s0_out_valid), 32'd0);
        check("arst_s0_ctrl",  32'(s0_out_ctrl),  32'(NOP));
        q1.delete();
        q0.delete();
        @(negedge clock);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        check("arst_s1_ready", 32'(s1_in_ready), 32'd1);
        check("arst_s0_ready", 32'(s0_in_ready), 32'd1);

        // Random traffic at 50% valid/ready with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
        end
        repeat (4) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("rand_s1_sb_empty", 32'(q1.size()), 32'd0);
        check("rand_s0_sb_empty", 32'(q0.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
